// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: I-cache and D-cache request sides, the memory port,
// and the per-owner grant/data/stall returns.
interface mem_arbiter_if;
  logic        i_req;
  logic        i_mem_enable;
  logic [15:0] i_mem_addr;
  logic        d_req;
  logic        d_wr;
  logic        d_mem_enable;
  logic [15:0] d_mem_addr;
  logic [15:0] d_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_grant;
  logic        d_grant;
  logic        i_data_valid;
  logic        d_data_valid;
  logic [15:0] i_rdata;
  logic [15:0] d_rdata;
  logic        i_stall;
  logic        d_stall;
  logic        d_write_done;

  // Requesters and the memory drive the arbiter through this side.
  modport master (
    output i_req, i_mem_enable, i_mem_addr, d_req, d_wr, d_mem_enable, d_mem_addr, d_wdata,
           mem_data_valid, mem_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, i_data_valid,
           d_data_valid, i_rdata, d_rdata, i_stall, d_stall, d_write_done
  );

  modport slave (
    input  i_req, i_mem_enable, i_mem_addr, d_req, d_wr, d_mem_enable, d_mem_addr, d_wdata,
           mem_data_valid, mem_rdata,
    output mem_enable, mem_wr, mem_addr, mem_wdata, i_grant, d_grant, i_data_valid,
           d_data_valid, i_rdata, d_rdata, i_stall, d_stall, d_write_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache fills and D-cache
// fills/single-word writes; a granted fill always drains BURST beats.
module mem_arbiter #(
  parameter int unsigned BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(BURST) + 1;
  localparam logic [CntW-1:0] BeatLast = CntW'(BURST - 1);

  typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_last_owner, w_last_owner_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_last_owner <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last_owner <= w_last_owner_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_owner_next = r_last_owner;
    unique case (r_state)
      StIdle: begin
        // On a tie the side that did not win last time goes first.
        if (bus.i_req && (!bus.d_req || r_last_owner)) begin
          w_state_next      = StIFill;
          w_cnt_next        = '0;
          w_last_owner_next = 1'b0;
        end else if (bus.d_req) begin
          w_state_next      = bus.d_wr ? StDWrite : StDFill;
          w_cnt_next        = '0;
          w_last_owner_next = 1'b1;
        end
      end
      StIFill, StDFill: begin
        // Requests are not sampled here: a fill drains its full burst even if req drops.
        if (bus.mem_data_valid) begin
          w_cnt_next = r_cnt + CntW'(1);
          if (r_cnt == BeatLast) w_state_next = StIdle;
        end
      end
      StDWrite: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_enable   = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.i_data_valid = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.d_write_done = 1'b0;
    unique case (r_state)
      StIFill: begin
        bus.mem_enable   = bus.i_mem_enable;
        bus.mem_addr     = bus.i_mem_addr;
        bus.i_data_valid = bus.mem_data_valid;
      end
      StDFill: begin
        bus.mem_enable   = bus.d_mem_enable;
        bus.mem_addr     = bus.d_mem_addr;
        bus.d_data_valid = bus.mem_data_valid;
      end
      StDWrite: begin
        bus.mem_enable   = 1'b1;
        bus.mem_wr       = 1'b1;
        bus.mem_addr     = bus.d_mem_addr;
        bus.mem_wdata    = bus.d_wdata;
        bus.d_write_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.i_grant = (r_state == StIFill);
  assign bus.d_grant = (r_state == StDFill) || (r_state == StDWrite);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
  assign bus.i_stall = bus.i_req & ~bus.i_grant;
  assign bus.d_stall = bus.d_req & ~bus.d_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level owner/beats-remaining model.
module tb_mem_arbiter;
  localparam int unsigned BURST = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if bus_if ();

  mem_arbiter #(.BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port (0 none, 1 I fill, 2 D fill, 3 D write),
  // beats still owed, and whether D won the most recent grant.
  int m_owner;
  int m_left;
  bit m_last_d;
  bit m_pick_d;

  always @(posedge clk) begin
    if (rst) begin
      m_owner  = 0;
      m_left   = 0;
      m_last_d = 1'b0;
    end else begin
      case (m_owner)
        0: begin
          if (bus_if.i_req || bus_if.d_req) begin
            m_pick_d = bus_if.d_req && (!bus_if.i_req || !m_last_d);
            m_owner  = m_pick_d ? (bus_if.d_wr ? 3 : 2) : 1;
            m_last_d = m_pick_d;
            m_left   = BURST;
          end
        end
        1, 2: begin
          if (bus_if.mem_data_valid) begin
            m_left = m_left - 1;
            if (m_left == 0) m_owner = 0;
          end
        end
        default: m_owner = 0;
      endcase
    end
  end

  function automatic logic [72:0] exp_out();
    logic me, mw, ig, dg, idv, ddv, wd;
    logic [15:0] ma, mwd;
    me = 0; mw = 0; ig = 0; dg = 0; idv = 0; ddv = 0; wd = 0; ma = '0; mwd = '0;
    case (m_owner)
      1: begin ig = 1; me = bus_if.i_mem_enable; ma = bus_if.i_mem_addr;
               idv = bus_if.mem_data_valid; end
      2: begin dg = 1; me = bus_if.d_mem_enable; ma = bus_if.d_mem_addr;
               ddv = bus_if.mem_data_valid; end
      3: begin dg = 1; me = 1; mw = 1; ma = bus_if.d_mem_addr; mwd = bus_if.d_wdata; wd = 1; end
      default: ;
    endcase
    return {me, mw, ma, mwd, ig, dg, idv, ddv, bus_if.mem_rdata, bus_if.mem_rdata,
            bus_if.i_req & ~ig, bus_if.d_req & ~dg, wd};
  endfunction

  wire logic [72:0] dut_vec = {bus_if.mem_enable, bus_if.mem_wr, bus_if.mem_addr,
    bus_if.mem_wdata, bus_if.i_grant, bus_if.d_grant, bus_if.i_data_valid,
    bus_if.d_data_valid, bus_if.i_rdata, bus_if.d_rdata, bus_if.i_stall, bus_if.d_stall,
    bus_if.d_write_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.i_req = 0; bus_if.i_mem_enable = 0; bus_if.i_mem_addr = '0;
    bus_if.d_req = 0; bus_if.d_wr = 0; bus_if.d_mem_enable = 0; bus_if.d_mem_addr = '0;
    bus_if.d_wdata = '0; bus_if.mem_data_valid = 0; bus_if.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    bus_if.i_req = 1; bus_if.d_req = 1; bus_if.mem_rdata = 16'hA5A5; bus_if.mem_data_valid = 1;
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if ({bus_if.i_grant, bus_if.d_grant, bus_if.mem_enable, bus_if.mem_wr, bus_if.i_data_valid,
         bus_if.d_data_valid, bus_if.d_write_done} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", dut_vec[56:51]);
    end
    n_tests++;
    if (bus_if.mem_addr !== 16'h0 || bus_if.mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h/%h required 0/0", bus_if.mem_addr, bus_if.mem_wdata);
    end
    n_tests++;
    if ({bus_if.i_stall, bus_if.d_stall} !== 2'b11 || bus_if.i_rdata !== 16'hA5A5 ||
        bus_if.d_rdata !== 16'hA5A5) begin
      n_fail++; $display("FAIL reset_pass: got stall %b rdata %h/%h required 11 a5a5",
                         {bus_if.i_stall, bus_if.d_stall}, bus_if.i_rdata, bus_if.d_rdata);
    end
    tick();
    rst = 0;
    idle_inputs();
    tick();
  endtask

  // I fill alone, with a D fill request arriving mid-burst and served afterwards.
  task automatic test_i_fill();
    int seen;
    seen = 0;
    bus_if.i_req = 1; bus_if.i_mem_enable = 1; bus_if.i_mem_addr = 16'h0040;
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0 || bus_if.i_stall !== 1 || bus_if.mem_enable !== 0) begin
      n_fail++; $display("FAIL ifill_pre: got grant %b stall %b en %b required 0 1 0",
                         bus_if.i_grant, bus_if.i_stall, bus_if.mem_enable);
    end
    tick();
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < 4; g++) begin
        bus_if.mem_data_valid = (g == 3);
        bus_if.mem_rdata = 16'h1000 + 16'(b);
        if (b == 4 && g == 0) begin
          bus_if.d_req = 1; bus_if.d_wr = 0; bus_if.d_mem_enable = 1; bus_if.d_mem_addr = 16'h0ABC;
        end
        @(negedge clk);
        if (bus_if.i_data_valid === 1'b1) seen++;
        n_tests++;
        if (bus_if.i_grant !== 1 || bus_if.d_data_valid !== 0 || bus_if.mem_addr !== 16'h0040 ||
            bus_if.mem_enable !== 1 || bus_if.mem_wr !== 0 || bus_if.d_stall !== (b >= 4)) begin
          n_fail++; $display("FAIL ifill_beat%0d: got ig %b ddv %b addr %h ds %b required 1 0 0040 %b",
                             b, bus_if.i_grant, bus_if.d_data_valid, bus_if.mem_addr,
                             bus_if.d_stall, (b >= 4));
        end
        tick();
      end
    end
    bus_if.mem_data_valid = 0;
    bus_if.i_req = 0;
    n_tests++;
    if (seen != 8) begin
      n_fail++; $display("FAIL ifill_count: got %0d beats required 8", seen);
    end
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0 || bus_if.d_grant !== 0 || bus_if.d_stall !== 1 ||
        bus_if.mem_enable !== 0) begin
      n_fail++; $display("FAIL ifill_gap: got ig %b dg %b ds %b en %b required 0 0 1 0",
                         bus_if.i_grant, bus_if.d_grant, bus_if.d_stall, bus_if.mem_enable);
    end
    tick();
    for (int b = 0; b < 8; b++) begin
      bus_if.mem_data_valid = 1;
      @(negedge clk);
      n_tests++;
      if (bus_if.d_grant !== 1 || bus_if.d_data_valid !== 1 || bus_if.mem_addr !== 16'h0ABC) begin
        n_fail++; $display("FAIL dfollow_beat%0d: got dg %b ddv %b addr %h required 1 1 0abc",
                           b, bus_if.d_grant, bus_if.d_data_valid, bus_if.mem_addr);
      end
      bus_if.d_req = 0;
      tick();
    end
    bus_if.mem_data_valid = 0;
    @(negedge clk);
    n_tests++;
    if (bus_if.d_grant !== 0) begin
      n_fail++; $display("FAIL dfollow_end: got dg %b required 0", bus_if.d_grant);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    logic [15:0] v;
    do_reset();
    bus_if.i_req = 1; bus_if.i_mem_enable = 1; bus_if.i_mem_addr = 16'h0111;
    bus_if.d_req = 1; bus_if.d_wr = 0; bus_if.d_mem_enable = 1; bus_if.d_mem_addr = 16'h0222;
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_if.d_grant !== 1 || bus_if.i_grant !== 0 || bus_if.i_stall !== 1 ||
        bus_if.mem_addr !== 16'h0222) begin
      n_fail++; $display("FAIL tie_first: got dg %b ig %b is %b addr %h required 1 0 1 0222",
                         bus_if.d_grant, bus_if.i_grant, bus_if.i_stall, bus_if.mem_addr);
    end
    tick();
    for (int b = 0; b < 8; b++) begin
      v = 16'($urandom);
      bus_if.mem_data_valid = 1; bus_if.mem_rdata = v;
      @(negedge clk);
      n_tests++;
      if (bus_if.d_data_valid !== 1 || bus_if.i_data_valid !== 0 || bus_if.d_rdata !== v) begin
        n_fail++; $display("FAIL tie_beat%0d: got ddv %b idv %b data %h required 1 0 %h",
                           b, bus_if.d_data_valid, bus_if.i_data_valid, bus_if.d_rdata, v);
      end
      tick();
    end
    bus_if.mem_data_valid = 0;
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0 || bus_if.d_grant !== 0 || bus_if.i_stall !== 1) begin
      n_fail++; $display("FAIL tie_gap: got ig %b dg %b is %b required 0 0 1",
                         bus_if.i_grant, bus_if.d_grant, bus_if.i_stall);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 1 || bus_if.d_grant !== 0 || bus_if.d_stall !== 1 ||
        bus_if.mem_addr !== 16'h0111) begin
      n_fail++; $display("FAIL tie_rr: got ig %b dg %b ds %b addr %h required 1 0 1 0111",
                         bus_if.i_grant, bus_if.d_grant, bus_if.d_stall, bus_if.mem_addr);
    end
    do_reset();
  endtask

  task automatic test_write();
    do_reset();
    bus_if.d_req = 1; bus_if.d_wr = 1; bus_if.d_mem_addr = 16'h1234; bus_if.d_wdata = 16'hBEEF;
    @(negedge clk);
    n_tests++;
    if (bus_if.mem_enable !== 0 || bus_if.d_write_done !== 0) begin
      n_fail++; $display("FAIL write_pre: got en %b done %b required 0 0",
                         bus_if.mem_enable, bus_if.d_write_done);
    end
    tick();
    bus_if.mem_data_valid = 1;
    @(negedge clk);
    n_tests++;
    if ({bus_if.mem_enable, bus_if.mem_wr, bus_if.d_write_done, bus_if.d_grant} !== 4'b1111 ||
        bus_if.mem_addr !== 16'h1234 || bus_if.mem_wdata !== 16'hBEEF ||
        bus_if.d_data_valid !== 0) begin
      n_fail++; $display("FAIL write_cycle: got ctl %b addr %h data %h ddv %b required 1111 1234 beef 0",
                         {bus_if.mem_enable, bus_if.mem_wr, bus_if.d_write_done, bus_if.d_grant},
                         bus_if.mem_addr, bus_if.mem_wdata, bus_if.d_data_valid);
    end
    bus_if.d_req = 0; bus_if.mem_data_valid = 0;
    tick();
    @(negedge clk);
    n_tests++;
    if ({bus_if.mem_enable, bus_if.mem_wr, bus_if.d_write_done, bus_if.d_grant} !== 4'b0 ||
        bus_if.mem_addr !== 16'h0 || bus_if.mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL write_after: got ctl %b addr %h data %h required 0000 0 0",
                         {bus_if.mem_enable, bus_if.mem_wr, bus_if.d_write_done, bus_if.d_grant},
                         bus_if.mem_addr, bus_if.mem_wdata);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus_if.d_req = 1; bus_if.d_mem_enable = 1; bus_if.d_mem_addr = 16'h0300;
    tick();
    bus_if.mem_data_valid = 1;
    tick(); tick(); tick();
    bus_if.mem_data_valid = 0; bus_if.d_req = 0;
    rst = 1;
    tick();
    rst = 0;
    bus_if.mem_data_valid = 1;
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0 || bus_if.d_grant !== 0 || bus_if.mem_enable !== 0 ||
        bus_if.i_data_valid !== 0 || bus_if.d_data_valid !== 0) begin
      n_fail++; $display("FAIL rstmid_idle: got ig %b dg %b en %b dv %b%b required 0 0 0 00",
                         bus_if.i_grant, bus_if.d_grant, bus_if.mem_enable,
                         bus_if.i_data_valid, bus_if.d_data_valid);
    end
    tick();
    bus_if.mem_data_valid = 0;
    bus_if.i_req = 1; bus_if.i_mem_enable = 1; bus_if.i_mem_addr = 16'h0400;
    tick();
    for (int b = 0; b < 8; b++) begin
      bus_if.mem_data_valid = 1;
      @(negedge clk);
      n_tests++;
      if (bus_if.i_grant !== 1 || bus_if.i_data_valid !== 1) begin
        n_fail++; $display("FAIL rstmid_beat%0d: got ig %b idv %b required 1 1",
                           b, bus_if.i_grant, bus_if.i_data_valid);
      end
      tick();
    end
    bus_if.mem_data_valid = 0; bus_if.i_req = 0;
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0) begin
      n_fail++; $display("FAIL rstmid_end: got ig %b required 0", bus_if.i_grant);
    end
    tick();
  endtask

  task automatic test_drop_req();
    do_reset();
    bus_if.i_req = 1; bus_if.i_mem_enable = 1; bus_if.i_mem_addr = 16'h0500;
    tick();
    for (int b = 0; b < 8; b++) begin
      bus_if.mem_data_valid = 1;
      if (b == 2) bus_if.i_req = 0;
      @(negedge clk);
      n_tests++;
      if (bus_if.i_grant !== 1 || bus_if.i_data_valid !== 1 || bus_if.i_stall !== 0) begin
        n_fail++; $display("FAIL drop_beat%0d: got ig %b idv %b is %b required 1 1 0",
                           b, bus_if.i_grant, bus_if.i_data_valid, bus_if.i_stall);
      end
      tick();
    end
    bus_if.mem_data_valid = 0;
    @(negedge clk);
    n_tests++;
    if (bus_if.i_grant !== 0) begin
      n_fail++; $display("FAIL drop_end: got ig %b required 0", bus_if.i_grant);
    end
    tick();
  endtask

  task automatic test_random();
    logic [72:0] e;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      bus_if.i_req = ($urandom_range(0, 2) != 0);
      bus_if.i_mem_enable = 1'($urandom);
      bus_if.i_mem_addr = 16'($urandom);
      bus_if.d_req = ($urandom_range(0, 2) != 0);
      bus_if.d_wr = ($urandom_range(0, 2) == 0);
      bus_if.d_mem_enable = 1'($urandom);
      bus_if.d_mem_addr = 16'($urandom);
      bus_if.d_wdata = 16'($urandom);
      bus_if.mem_data_valid = 1'($urandom);
      bus_if.mem_rdata = 16'($urandom);
      @(negedge clk);
      e = exp_out();
      n_tests++;
      if (dut_vec !== e) begin
        n_fail++; $display("FAIL random_c%0d: got %h required %h", c, dut_vec, e);
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_i_fill();
    test_tie();
    test_write();
    test_reset_mid_burst();
    test_drop_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
